// File: rtl/lc3_ctrl_pkg.sv
// lc3_ctrl_pkg: shared types and encodings for the LC-3 control unit.
// The state list grows by the LDI/STI states only when LC3_INDIRECT_EN is defined.
package lc3_ctrl_pkg;

    localparam logic [3:0] OpBr    = 4'b0000;
    localparam logic [3:0] OpAdd   = 4'b0001;
    localparam logic [3:0] OpJsr   = 4'b0100;
    localparam logic [3:0] OpAnd   = 4'b0101;
    localparam logic [3:0] OpLdr   = 4'b0110;
    localparam logic [3:0] OpStr   = 4'b0111;
    localparam logic [3:0] OpNot   = 4'b1001;
    localparam logic [3:0] OpJmp   = 4'b1100;
    localparam logic [3:0] OpPause = 4'b1101;
`ifdef LC3_INDIRECT_EN
    localparam logic [3:0] OpLdi   = 4'b1010;
    localparam logic [3:0] OpSti   = 4'b1011;
`endif

    localparam logic [1:0] PcmuxPc1   = 2'b00;
    localparam logic [1:0] PcmuxAdder = 2'b01;
    localparam logic [1:0] PcmuxBus   = 2'b10;

    localparam logic [1:0] Addr2Zero  = 2'b00;
    localparam logic [1:0] Addr2Off6  = 2'b01;
    localparam logic [1:0] Addr2Off9  = 2'b10;
    localparam logic [1:0] Addr2Off11 = 2'b11;

    localparam logic [1:0] AlukAdd   = 2'b00;
    localparam logic [1:0] AlukAnd   = 2'b01;
    localparam logic [1:0] AlukNot   = 2'b10;
    localparam logic [1:0] AlukPassA = 2'b11;

    typedef enum logic [4:0] {
        StHalted, StFetch1, StFetch2, StFetch3, StDecode,
        StAdd, StAnd, StNot, StBr0, StBr1, StJmp, StJsr0, StJsr1,
        StLdr0, StLdr1, StLdr2, StStr0, StStr1, StStr2,
`ifdef LC3_INDIRECT_EN
        StPause0, StPauseHi, StPauseLo,
        StLdi0, StLdi1, StLdi2, StSti0, StSti1, StSti2
`else
        StPause0, StPauseHi, StPauseLo
`endif
    } state_t;

    typedef struct packed {
        logic       ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
        logic       gate_pc, gate_mdr, gate_alu, gate_marmux;
        logic [1:0] pcmux, addr2mux, aluk;
        logic       addr1mux, drmux, sr1mux, sr2mux, mio_en, mem_oe, mem_we;
    } ctrl_t;

    // Control word for a state; mem_last marks the final cycle of a read wait
    function automatic ctrl_t decode_ctrl(state_t st, logic mem_last, logic ir_5, logic ir_11);
        ctrl_t c;
        c = '0;
        case (st)
            StFetch1: begin
                c.gate_pc = 1'b1; c.ld_mar = 1'b1; c.pcmux = PcmuxPc1; c.ld_pc = 1'b1;
            end
`ifdef LC3_INDIRECT_EN
            StLdi1, StSti1,
`endif
            StFetch2, StLdr1: begin
                c.mem_oe = 1'b1; c.mio_en = 1'b1; c.ld_mdr = mem_last;
            end
            StFetch3: begin
                c.gate_mdr = 1'b1; c.ld_ir = 1'b1;
            end
            StDecode: c.ld_ben = 1'b1;
            StAdd, StAnd: begin
                c.gate_alu = 1'b1; c.ld_reg = 1'b1; c.ld_cc = 1'b1;
                c.aluk = (st == StAnd) ? AlukAnd : AlukAdd;
                c.sr1mux = 1'b1; c.sr2mux = ir_5;
            end
            StNot: begin
                c.aluk = AlukNot; c.gate_alu = 1'b1; c.ld_reg = 1'b1; c.ld_cc = 1'b1;
                c.sr1mux = 1'b1;
            end
            StBr1: begin
                c.addr1mux = 1'b0; c.addr2mux = Addr2Off9; c.pcmux = PcmuxAdder; c.ld_pc = 1'b1;
            end
            StJmp: begin
                c.addr1mux = 1'b1; c.addr2mux = Addr2Zero; c.sr1mux = 1'b1;
                c.pcmux = PcmuxAdder; c.ld_pc = 1'b1;
            end
            StJsr0: begin
                c.gate_pc = 1'b1; c.drmux = 1'b1; c.ld_reg = 1'b1;
            end
            StJsr1: begin
                // JSRR base register lives in IR[8:6]
                c.addr1mux = ~ir_11; c.sr1mux = ~ir_11;
                c.addr2mux = ir_11 ? Addr2Off11 : Addr2Zero;
                c.pcmux = PcmuxAdder; c.ld_pc = 1'b1;
            end
            StLdr0, StStr0: begin
                c.gate_marmux = 1'b1; c.addr1mux = 1'b1; c.sr1mux = 1'b1;
                c.addr2mux = Addr2Off6; c.ld_mar = 1'b1;
            end
            StLdr2: begin
                c.gate_mdr = 1'b1; c.ld_reg = 1'b1; c.ld_cc = 1'b1;
            end
            StStr1: begin
                c.aluk = AlukPassA; c.sr1mux = 1'b0; c.gate_alu = 1'b1;
                c.mio_en = 1'b0; c.ld_mdr = 1'b1;
            end
            StStr2: c.mem_we = 1'b1;
            StPause0: c.ld_led = 1'b1;
`ifdef LC3_INDIRECT_EN
            StLdi0, StSti0: begin
                c.gate_marmux = 1'b1; c.addr1mux = 1'b0; c.addr2mux = Addr2Off9;
                c.ld_mar = 1'b1;
            end
            StLdi2, StSti2: begin
                c.gate_mdr = 1'b1; c.ld_mar = 1'b1;
            end
`endif
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/lc3_control_fsm_mem_wait_ctr.sv
// lc3_mem_wait_ctr: counts 0..MEM_WAIT while a memory strobe state is active.
module lc3_mem_wait_ctr #(
    parameter int unsigned MEM_WAIT = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_active,
    output logic o_done,
    output logic o_next_last
);
    localparam logic [2:0] Last = 3'(MEM_WAIT);

    logic [2:0] r_cnt;
    logic [2:0] w_cnt_next;

    // Advance while waiting; the done cycle (or any idle cycle) reloads 0 for the next access
    always_comb begin
        o_done      = (r_cnt == Last);
        w_cnt_next  = (i_active && !o_done) ? r_cnt + 3'd1 : 3'd0;
        o_next_last = (w_cnt_next == Last);
    end

    // Counter register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= 3'd0;
        end else begin
            r_cnt <= w_cnt_next;
        end
    end

endmodule

// File: rtl/lc3_control_fsm.sv
// lc3_control_fsm: LC-3 ISDU. Fetch/decode/execute FSM with registered Moore outputs.
// Define LC3_INDIRECT_EN to add LDI/STI; otherwise opcodes 1010/1011 act as NOPs.
module lc3_control_fsm
    import lc3_ctrl_pkg::*;
#(
    parameter int unsigned MEM_WAIT = 2
) (
    input  logic       Clk,
    input  logic       Reset_al,
    input  logic       Run,
    input  logic       Continue,
    input  logic [3:0] Opcode,
    input  logic       IR_5,
    input  logic       IR_11,
    input  logic       BEN,
    output logic       LD_MAR,
    output logic       LD_MDR,
    output logic       LD_IR,
    output logic       LD_BEN,
    output logic       LD_CC,
    output logic       LD_REG,
    output logic       LD_PC,
    output logic       LD_LED,
    output logic       GatePC,
    output logic       GateMDR,
    output logic       GateALU,
    output logic       GateMARMUX,
    output logic [1:0] PCMUX,
    output logic [1:0] ADDR2MUX,
    output logic [1:0] ALUK,
    output logic       ADDR1MUX,
    output logic       DRMUX,
    output logic       SR1MUX,
    output logic       SR2MUX,
    output logic       MIO_EN,
    output logic       Mem_OE,
    output logic       Mem_WE
);
    state_t r_state, w_state_next;
    ctrl_t  r_ctrl;
    logic   w_mem_state, w_mem_done, w_mem_last_next;

    // States that hold a memory strobe and run the wait counter
    always_comb begin
        w_mem_state = (r_state == StFetch2) || (r_state == StLdr1) || (r_state == StStr2);
`ifdef LC3_INDIRECT_EN
        w_mem_state = w_mem_state || (r_state == StLdi1) || (r_state == StSti1);
`endif
    end

    lc3_mem_wait_ctr #(
        .MEM_WAIT (MEM_WAIT)
    ) u_wait_ctr (
        .i_clk       (Clk),
        .i_rst_n     (Reset_al),
        .i_active    (w_mem_state),
        .o_done      (w_mem_done),
        .o_next_last (w_mem_last_next)
    );

    // Next-state selection
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StHalted:  if (Run) w_state_next = StFetch1;
            StFetch1:  w_state_next = StFetch2;
            StFetch2:  if (w_mem_done) w_state_next = StFetch3;
            StFetch3:  w_state_next = StDecode;
            StDecode: begin
                case (Opcode)
                    OpAdd:   w_state_next = StAdd;
                    OpAnd:   w_state_next = StAnd;
                    OpNot:   w_state_next = StNot;
                    OpBr:    w_state_next = StBr0;
                    OpJmp:   w_state_next = StJmp;
                    OpJsr:   w_state_next = StJsr0;
                    OpLdr:   w_state_next = StLdr0;
                    OpStr:   w_state_next = StStr0;
                    OpPause: w_state_next = StPause0;
`ifdef LC3_INDIRECT_EN
                    OpLdi:   w_state_next = StLdi0;
                    OpSti:   w_state_next = StSti0;
`endif
                    default: w_state_next = StFetch1;
                endcase
            end
            StBr0:     w_state_next = BEN ? StBr1 : StFetch1;
            StJsr0:    w_state_next = StJsr1;
            StLdr0:    w_state_next = StLdr1;
            StLdr1:    if (w_mem_done) w_state_next = StLdr2;
            StStr0:    w_state_next = StStr1;
            StStr1:    w_state_next = StStr2;
            StStr2:    if (w_mem_done) w_state_next = StFetch1;
            StPause0:  w_state_next = StPauseHi;
            StPauseHi: if (Continue) w_state_next = StPauseLo;
            StPauseLo: if (!Continue) w_state_next = StFetch1;
            StAdd, StAnd, StNot, StBr1, StJmp, StJsr1, StLdr2: w_state_next = StFetch1;
`ifdef LC3_INDIRECT_EN
            StLdi0:    w_state_next = StLdi1;
            StLdi1:    if (w_mem_done) w_state_next = StLdi2;
            StLdi2:    w_state_next = StLdr1;
            StSti0:    w_state_next = StSti1;
            StSti1:    if (w_mem_done) w_state_next = StSti2;
            StSti2:    w_state_next = StStr1;
`endif
            default:   w_state_next = StHalted;
        endcase
    end

    // State register plus control word decoded from the state being entered
    always_ff @(posedge Clk or negedge Reset_al) begin
        if (!Reset_al) begin
            r_state <= StHalted;
            r_ctrl  <= '0;
        end else begin
            r_state <= w_state_next;
            r_ctrl  <= decode_ctrl(w_state_next, w_mem_last_next, IR_5, IR_11);
        end
    end

    assign LD_MAR     = r_ctrl.ld_mar;
    assign LD_MDR     = r_ctrl.ld_mdr;
    assign LD_IR      = r_ctrl.ld_ir;
    assign LD_BEN     = r_ctrl.ld_ben;
    assign LD_CC      = r_ctrl.ld_cc;
    assign LD_REG     = r_ctrl.ld_reg;
    assign LD_PC      = r_ctrl.ld_pc;
    assign LD_LED     = r_ctrl.ld_led;
    assign GatePC     = r_ctrl.gate_pc;
    assign GateMDR    = r_ctrl.gate_mdr;
    assign GateALU    = r_ctrl.gate_alu;
    assign GateMARMUX = r_ctrl.gate_marmux;
    assign PCMUX      = r_ctrl.pcmux;
    assign ADDR2MUX   = r_ctrl.addr2mux;
    assign ALUK       = r_ctrl.aluk;
    assign ADDR1MUX   = r_ctrl.addr1mux;
    assign DRMUX      = r_ctrl.drmux;
    assign SR1MUX     = r_ctrl.sr1mux;
    assign SR2MUX     = r_ctrl.sr2mux;
    assign MIO_EN     = r_ctrl.mio_en;
    assign Mem_OE     = r_ctrl.mem_oe;
    assign Mem_WE     = r_ctrl.mem_we;

endmodule

// File: tb/tb_lc3_control_fsm.sv
// tb_lc3_control_fsm: instruction-level reference model producing the expected
// per-cycle control word for each instruction, compared against the DUT.
module tb_lc3_control_fsm;
    localparam int unsigned MW = 2;

    logic       Clk = 1'b0;
    logic       Reset_al, Run, Continue, IR_5, IR_11, BEN;
    logic [3:0] Opcode;
    logic       LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
    logic       GatePC, GateMDR, GateALU, GateMARMUX;
    logic [1:0] PCMUX, ADDR2MUX, ALUK;
    logic       ADDR1MUX, DRMUX, SR1MUX, SR2MUX, MIO_EN, Mem_OE, Mem_WE;

    typedef struct packed {
        logic       ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
        logic       gate_pc, gate_mdr, gate_alu, gate_marmux;
        logic [1:0] pcmux, addr2mux, aluk;
        logic       addr1mux, drmux, sr1mux, sr2mux, mio_en, mem_oe, mem_we;
    } outs_t;

    outs_t obs, exp_o;
    outs_t q_exp[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    always #5 Clk = ~Clk;

    lc3_control_fsm #(.MEM_WAIT(MW)) dut (
        .Clk(Clk), .Reset_al(Reset_al), .Run(Run), .Continue(Continue), .Opcode(Opcode),
        .IR_5(IR_5), .IR_11(IR_11), .BEN(BEN),
        .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_BEN(LD_BEN), .LD_CC(LD_CC),
        .LD_REG(LD_REG), .LD_PC(LD_PC), .LD_LED(LD_LED),
        .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU), .GateMARMUX(GateMARMUX),
        .PCMUX(PCMUX), .ADDR2MUX(ADDR2MUX), .ALUK(ALUK), .ADDR1MUX(ADDR1MUX), .DRMUX(DRMUX),
        .SR1MUX(SR1MUX), .SR2MUX(SR2MUX), .MIO_EN(MIO_EN), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE)
    );

    assign obs = {LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
                  GatePC, GateMDR, GateALU, GateMARMUX, PCMUX, ADDR2MUX, ALUK,
                  ADDR1MUX, DRMUX, SR1MUX, SR2MUX, MIO_EN, Mem_OE, Mem_WE};

    // ---------------- reference model ----------------
    function automatic outs_t fetch1_o();
        outs_t o = '0;
        o.gate_pc = 1'b1; o.ld_mar = 1'b1; o.ld_pc = 1'b1;
        return o;
    endfunction

    function automatic void push_read();
        for (int i = 0; i <= int'(MW); i++) begin
            outs_t o = '0;
            o.mem_oe = 1'b1; o.mio_en = 1'b1; o.ld_mdr = (i == int'(MW));
            q_exp.push_back(o);
        end
    endfunction

    function automatic void push_store_tail();
        outs_t o = '0;
        o.aluk = 2'b11; o.gate_alu = 1'b1; o.ld_mdr = 1'b1;
        q_exp.push_back(o);
        for (int i = 0; i <= int'(MW); i++) begin
            o = '0; o.mem_we = 1'b1;
            q_exp.push_back(o);
        end
    endfunction

    function automatic void model_instr(logic [3:0] op, logic ir5, logic ir11, logic ben);
        outs_t o;
        q_exp.push_back(fetch1_o());
        push_read();
        o = '0; o.gate_mdr = 1'b1; o.ld_ir = 1'b1; q_exp.push_back(o);
        o = '0; o.ld_ben = 1'b1; q_exp.push_back(o);
        o = '0;
        case (op)
            4'b0001, 4'b0101, 4'b1001: begin
                o.gate_alu = 1'b1; o.ld_reg = 1'b1; o.ld_cc = 1'b1; o.sr1mux = 1'b1;
                o.aluk = (op == 4'b0001) ? 2'b00 : (op == 4'b0101) ? 2'b01 : 2'b10;
                o.sr2mux = (op == 4'b1001) ? 1'b0 : ir5;
                q_exp.push_back(o);
            end
            4'b0000: begin
                q_exp.push_back(o);
                if (ben) begin
                    o.addr2mux = 2'b10; o.pcmux = 2'b01; o.ld_pc = 1'b1;
                    q_exp.push_back(o);
                end
            end
            4'b1100: begin
                o.addr1mux = 1'b1; o.sr1mux = 1'b1; o.pcmux = 2'b01; o.ld_pc = 1'b1;
                q_exp.push_back(o);
            end
            4'b0100: begin
                o.gate_pc = 1'b1; o.drmux = 1'b1; o.ld_reg = 1'b1;
                q_exp.push_back(o);
                o = '0; o.pcmux = 2'b01; o.ld_pc = 1'b1;
                if (ir11) o.addr2mux = 2'b11;
                else begin o.addr1mux = 1'b1; o.sr1mux = 1'b1; end
                q_exp.push_back(o);
            end
            4'b0110, 4'b0111: begin
                o.gate_marmux = 1'b1; o.addr1mux = 1'b1; o.sr1mux = 1'b1;
                o.addr2mux = 2'b01; o.ld_mar = 1'b1;
                q_exp.push_back(o);
                if (op == 4'b0110) begin
                    push_read();
                    o = '0; o.gate_mdr = 1'b1; o.ld_reg = 1'b1; o.ld_cc = 1'b1;
                    q_exp.push_back(o);
                end else begin
                    push_store_tail();
                end
            end
`ifdef LC3_INDIRECT_EN
            4'b1010, 4'b1011: begin
                o.gate_marmux = 1'b1; o.addr2mux = 2'b10; o.ld_mar = 1'b1;
                q_exp.push_back(o);
                push_read();
                o = '0; o.gate_mdr = 1'b1; o.ld_mar = 1'b1;
                q_exp.push_back(o);
                if (op == 4'b1010) begin
                    push_read();
                    o = '0; o.gate_mdr = 1'b1; o.ld_reg = 1'b1; o.ld_cc = 1'b1;
                    q_exp.push_back(o);
                end else begin
                    push_store_tail();
                end
            end
`endif
            default: ;
        endcase
    endfunction

    // Reset, release with Run=1; leaves the DUT in its first fetch cycle (#1 after the edge)
    task automatic start_run();
        @(negedge Clk); Reset_al = 1'b0; Run = 1'b0; Continue = 1'b0;
        @(negedge Clk); Reset_al = 1'b1; Run = 1'b1;
        @(posedge Clk); #1; Run = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        Run = 1'b1;
        #2;
        n_cmp++;
        if (obs !== '0) begin n_bad++; $display("FAIL reset_async: got %h want 0", obs); end
        @(posedge Clk); #1;
        n_cmp++;
        if (obs !== '0) begin n_bad++; $display("FAIL reset_held: got %h want 0", obs); end
        @(negedge Clk); Reset_al = 1'b1; Run = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge Clk); #1;
            n_cmp++;
            if (obs !== '0) begin n_bad++; $display("FAIL halted_idle %0d: got %h want 0", i, obs); end
        end
        Run = 1'b1;
        @(posedge Clk); #1;
        Run = 1'b0;
        n_cmp++;
        if (obs !== fetch1_o()) begin
            n_bad++; $display("FAIL run_to_fetch1: got %h want %h", obs, fetch1_o());
        end
    endtask

    task automatic test_alu();
        logic [3:0] ops[4] = '{4'b0001, 4'b0001, 4'b0101, 4'b1001};
        logic       imm[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        start_run();
        for (int k = 0; k < 4; k++) begin
            Opcode = ops[k]; IR_5 = imm[k]; IR_11 = 1'b0; BEN = 1'b0;
            model_instr(ops[k], imm[k], 1'b0, 1'b0);
            for (int s = 0; q_exp.size() != 0; s++) begin
                exp_o = q_exp.pop_front(); n_cmp++;
                if (obs !== exp_o) begin
                    n_bad++; $display("FAIL alu op%b step %0d: got %h want %h", ops[k], s, obs, exp_o);
                end
                @(posedge Clk); #1;
            end
        end
    endtask

    task automatic test_branch();
        start_run();
        for (int k = 0; k < 2; k++) begin
            Opcode = 4'b0000; BEN = (k == 1); IR_5 = 1'b0; IR_11 = 1'b0;
            model_instr(4'b0000, 1'b0, 1'b0, BEN);
            for (int s = 0; q_exp.size() != 0; s++) begin
                exp_o = q_exp.pop_front(); n_cmp++;
                if (obs !== exp_o) begin
                    n_bad++; $display("FAIL branch ben=%0d step %0d: got %h want %h", k, s, obs, exp_o);
                end
                @(posedge Clk); #1;
            end
        end
    endtask

    task automatic test_store();
        start_run();
        Opcode = 4'b0111; IR_5 = 1'b1; IR_11 = 1'b1; BEN = 1'b1;
        model_instr(4'b0111, 1'b1, 1'b1, 1'b1);
        for (int s = 0; q_exp.size() != 0; s++) begin
            exp_o = q_exp.pop_front(); n_cmp++;
            if (obs !== exp_o) begin
                n_bad++; $display("FAIL store step %0d: got %h want %h", s, obs, exp_o);
            end
            @(posedge Clk); #1;
        end
        n_cmp++;
        if (obs !== fetch1_o()) begin
            n_bad++; $display("FAIL store_return: got %h want %h", obs, fetch1_o());
        end
    endtask

    task automatic test_pause();
        outs_t led = '0;
        led.ld_led = 1'b1;
        start_run();
        Opcode = 4'b1101; IR_5 = 1'b0; IR_11 = 1'b0; BEN = 1'b0;
        model_instr(4'b1101, 1'b0, 1'b0, 1'b0);
        for (int s = 0; q_exp.size() != 0; s++) begin
            exp_o = q_exp.pop_front(); n_cmp++;
            if (obs !== exp_o) begin
                n_bad++; $display("FAIL pause_fetch step %0d: got %h want %h", s, obs, exp_o);
            end
            @(posedge Clk); #1;
        end
        n_cmp++;
        if (obs !== led) begin n_bad++; $display("FAIL pause_led: got %h want %h", obs, led); end
        for (int i = 0; i < 3; i++) begin
            @(posedge Clk); #1;
            n_cmp++;
            if (obs !== '0) begin n_bad++; $display("FAIL pause_wait_hi %0d: got %h want 0", i, obs); end
        end
        Continue = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge Clk); #1;
            n_cmp++;
            if (obs !== '0) begin n_bad++; $display("FAIL pause_hold %0d: got %h want 0", i, obs); end
        end
        Continue = 1'b0;
        @(posedge Clk); #1;
        n_cmp++;
        if (obs !== fetch1_o()) begin
            n_bad++; $display("FAIL pause_exit: got %h want %h", obs, fetch1_o());
        end
    endtask

    task automatic test_reset_mid_fetch();
        start_run();
        Opcode = 4'b0011; IR_5 = 1'b0; IR_11 = 1'b0; BEN = 1'b0;
        @(posedge Clk); #1;
        n_cmp++;
        if (Mem_OE !== 1'b1) begin n_bad++; $display("FAIL midfetch_oe: got %b want 1", Mem_OE); end
        #2; Reset_al = 1'b0;
        #1;
        n_cmp++;
        if (obs !== '0) begin n_bad++; $display("FAIL midfetch_reset: got %h want 0", obs); end
        Run = 1'b1;
        @(negedge Clk); Reset_al = 1'b1;
        @(posedge Clk); #1;
        Run = 1'b0;
        model_instr(4'b0011, 1'b0, 1'b0, 1'b0);
        for (int s = 0; q_exp.size() != 0; s++) begin
            exp_o = q_exp.pop_front(); n_cmp++;
            if (obs !== exp_o) begin
                n_bad++; $display("FAIL midfetch_restart step %0d: got %h want %h", s, obs, exp_o);
            end
            @(posedge Clk); #1;
        end
    endtask

    task automatic test_random();
        logic [3:0] op;
        start_run();
        for (int k = 0; k < 150; k++) begin
            op = 4'($urandom_range(0, 15));
            if (op == 4'b1101) op = 4'b0110;
            Opcode = op; IR_5 = 1'($urandom); IR_11 = 1'($urandom); BEN = 1'($urandom);
            model_instr(op, IR_5, IR_11, BEN);
            for (int s = 0; q_exp.size() != 0; s++) begin
                exp_o = q_exp.pop_front(); n_cmp++;
                if (obs !== exp_o) begin
                    n_bad++;
                    $display("FAIL random #%0d op%b step %0d: got %h want %h", k, op, s, obs, exp_o);
                end
                @(posedge Clk); #1;
            end
        end
    endtask

    initial begin
        Reset_al = 1'b0; Run = 1'b0; Continue = 1'b0;
        Opcode = 4'b0000; IR_5 = 1'b0; IR_11 = 1'b0; BEN = 1'b0;
        test_reset();
        test_alu();
        test_branch();
        test_store();
        test_pause();
        test_reset_mid_fetch();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
